// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 systolic array result path: element geometry,
// drain FSM states and the settle latency agreed with the operand feeder.
package matrix_pkg;

   localparam int N_ELEM            = 9;
   localparam int DATA_W            = 8;
   localparam int IDX_W             = 4;
   localparam int SETTLE_CYCLES_DEF = 8;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } drain_state_t;

endpackage

// File: rtl/result_snapshot_buf.sv
// 9x8 parallel-load register holding one frozen set of PE results, read back
// one element at a time by index.
module result_snapshot_buf
   import matrix_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  logic [N_ELEM*DATA_W-1:0]   load_data,
   input  logic [IDX_W-1:0]           rd_idx,
   output logic [DATA_W-1:0]          rd_data
);

   logic [DATA_W-1:0] mem [N_ELEM];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < N_ELEM; i++) mem[i] <= load_data[i*DATA_W +: DATA_W];
      end
   end

   // Indices past the last element read as zero rather than aliasing.
   always_comb begin
      rd_data = '0;
      if (rd_idx <= LAST_IDX) rd_data = mem[rd_idx];
   end

endmodule

// File: rtl/matrix_result_drain.sv
// Clears the PE accumulators, waits for the array to settle, snapshots the nine
// results and streams them row-major over a valid/ready port, then pulses done.
module matrix_result_drain
   import matrix_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [DATA_W-1:0]  c0,
   input  logic [DATA_W-1:0]  c1,
   input  logic [DATA_W-1:0]  c2,
   input  logic [DATA_W-1:0]  c3,
   input  logic [DATA_W-1:0]  c4,
   input  logic [DATA_W-1:0]  c5,
   input  logic [DATA_W-1:0]  c6,
   input  logic [DATA_W-1:0]  c7,
   input  logic [DATA_W-1:0]  c8,
   output logic               acc_clear,
   output logic [DATA_W-1:0]  out_data,
   output logic [IDX_W-1:0]   out_index,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output drain_state_t       dbg_state
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   drain_state_t       state;
   logic [3:0]         cnt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   next_idx;
   logic [DATA_W-1:0]  next_data;
   logic               snap_load;

   assign dbg_state = state;
   assign snap_load = (state == ST_SETTLE) && (cnt == SETTLE_LAST);
   assign next_idx  = idx + 4'd1;

   result_snapshot_buf u_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (snap_load),
      .load_data ({c8, c7, c6, c5, c4, c3, c2, c1, c0}),
      .rd_idx    (next_idx),
      .rd_data   (next_data)
   );

   // Handshake: a beat transfers on a rising edge where out_valid & out_ready;
   // once out_valid rises, out_data/out_index/out_last hold until that transfer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         out_data  <= '0;
         out_index <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         acc_clear <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         acc_clear <= 1'b0;
         done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_SETTLE;
                  cnt       <= '0;
                  acc_clear <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_SETTLE: begin
               cnt <= cnt + 4'd1;
               if (cnt == SETTLE_LAST) begin
                  // The buffer loads on this same edge, so the first beat comes straight from c0.
                  state     <= ST_STREAM;
                  idx       <= '0;
                  out_data  <= c0;
                  out_index <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (out_valid && out_ready) begin
                  if (idx == LAST_IDX) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx       <= next_idx;
                     out_index <= next_idx;
                     out_data  <= next_data;
                     out_last  <= (next_idx == LAST_IDX);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Bench for matrix_result_drain: three instances (settle 8, 1, 15) share c* and
// reset; each transaction is checked against a queue of the values captured at start.
module tb_matrix_result_drain;
   import matrix_pkg::*;

   function automatic int settle_of(input int k);
      return (k == 0) ? 8 : (k == 1) ? 1 : 15;
   endfunction

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        c [9];
   logic [2:0]        start_v = '0;
   logic [2:0]        ready_v = '0;
   logic [2:0]        acc_clear_v, out_valid_v, out_last_v, busy_v, done_v;
   logic [2:0][7:0]   out_data_v;
   logic [2:0][3:0]   out_index_v;
   logic [2:0][1:0]   st_v;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      matrix_result_drain #(.SETTLE_CYCLES(settle_of(g))) dut (
         .clk       (clk),
         .reset     (reset),
         .start     (start_v[g]),
         .c0        (c[0]),
         .c1        (c[1]),
         .c2        (c[2]),
         .c3        (c[3]),
         .c4        (c[4]),
         .c5        (c[5]),
         .c6        (c[6]),
         .c7        (c[7]),
         .c8        (c[8]),
         .acc_clear (acc_clear_v[g]),
         .out_data  (out_data_v[g]),
         .out_index (out_index_v[g]),
         .out_valid (out_valid_v[g]),
         .out_ready (ready_v[g]),
         .out_last  (out_last_v[g]),
         .busy      (busy_v[g]),
         .done      (done_v[g]),
         .dbg_state (st_v[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Called at a negedge with instance k idle; returns at a negedge with k idle.
   // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
   task automatic run_txn(input int k, input int ready_mode, input bit fixed_vals,
                          input bit isolate, input bit poke_start, input bit abort4);
      logic [7:0] exp_q[$];
      logic [11:0] prev_beat;
      int s, cyc, n_clr, n_done, n_acc, n_vcyc, last_acc, exp_idx;
      bit first_seen, fin, aborted, prev_stall, r;
      s = settle_of(k);
      cyc = 0; n_clr = 0; n_done = 0; n_acc = 0; n_vcyc = 0; last_acc = -10; exp_idx = 0;
      first_seen = 0; fin = 0; aborted = 0; prev_stall = 0; prev_beat = '0;
      for (int i = 0; i < 9; i++) begin
         c[i] = fixed_vals ? 8'(i + 1) : 8'($urandom_range(0, 254));
         exp_q.push_back(c[i]);
      end
      start_v[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[k] = 1'b0;
      cyc = 1;
      check("acc_clear_t1", acc_clear_v[k], 1);
      check("busy_t1", busy_v[k], 1);
      while (!fin && cyc < 200) begin
         if (acc_clear_v[k]) n_clr++;
         if (done_v[k]) begin
            n_done++;
            check("done_after_last", cyc, last_acc + 1);
            check("all_beats_sent", exp_q.size(), 0);
            fin = 1;
         end else begin
            if (out_valid_v[k]) begin
               n_vcyc++;
               if (!first_seen) begin
                  check("first_beat_cycle", cyc, s + 1);
                  first_seen = 1;
                  if (isolate) for (int i = 0; i < 9; i++) c[i] = 8'hFF;
               end
               if (prev_stall) check("stall_hold", {out_index_v[k], out_data_v[k]}, prev_beat);
               if (exp_q.size() == 0) check("extra_beat", 1, 0);
               else check("beat_data", out_data_v[k], exp_q[0]);
               check("beat_index", out_index_v[k], exp_idx);
               check("beat_last", out_last_v[k], exp_idx == 8);
            end else if (prev_stall) begin
               check("no_retract", out_valid_v[k], 1);
            end
            case (ready_mode)
               0:       r = 1'b1;
               1:       r = ((n_vcyc - 1) % 3 == 0);
               default: r = 1'($urandom_range(0, 1));
            endcase
            ready_v[k] = r;
            start_v[k] = poke_start && (cyc == 2 || cyc == s + 3);
            prev_stall = 0;
            if (out_valid_v[k] && r) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               exp_idx++;
               n_acc++;
               last_acc = cyc;
               if (abort4 && n_acc == 4) begin
                  reset = 1'b0;
                  start_v[k] = 1'b0;
                  @(negedge clk);
                  check("abort_state", st_v[k], ST_IDLE);
                  check("abort_valid", out_valid_v[k], 0);
                  check("abort_busy", busy_v[k], 0);
                  check("abort_done", done_v[k], 0);
                  reset = 1'b1;
                  aborted = 1;
                  fin = 1;
               end
            end else if (out_valid_v[k]) begin
               prev_stall = 1;
               prev_beat = {out_index_v[k], out_data_v[k]};
            end
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) begin
         check("timeout", 0, 1);
      end else if (!aborted) begin
         start_v[k] = poke_start;
         @(negedge clk);
         start_v[k] = 1'b0;
         check("busy_drop", busy_v[k], 0);
         check("done_one_cycle", done_v[k], 0);
         check("idle_after_done", st_v[k], ST_IDLE);
         check("no_extra_clear", acc_clear_v[k], 0);
         check("acc_clear_count", n_clr, 1);
         check("done_count", n_done, 1);
      end
   endtask

   initial begin
      for (int i = 0; i < 9; i++) c[i] = 8'h00;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_state", st_v[k], ST_IDLE);
         check("rst_outs", {out_valid_v[k], out_last_v[k], acc_clear_v[k], busy_v[k], done_v[k]}, 0);
         check("rst_beat", {out_index_v[k], out_data_v[k]}, 0);
      end
      reset = 1'b1;
      @(negedge clk);

      run_txn(0, 0, 1, 0, 0, 0);   // basic stream of 1..9
      run_txn(0, 0, 0, 1, 0, 0);   // c* forced to FF after snapshot
      run_txn(0, 1, 0, 0, 0, 0);   // ready 1,0,0,...
      run_txn(0, 2, 0, 0, 0, 0);   // random ready
      run_txn(0, 0, 0, 0, 1, 0);   // start while busy
      run_txn(0, 2, 0, 0, 1, 1);   // reset after beat 4
      run_txn(0, 0, 0, 0, 0, 0);   // fresh start after abort
      run_txn(1, 0, 0, 0, 0, 0);   // settle 1, back to back
      run_txn(1, 1, 0, 0, 1, 0);
      run_txn(2, 0, 0, 0, 0, 0);   // settle 15, back to back
      run_txn(2, 2, 0, 1, 0, 0);
      for (int n = 0; n < 4; n++) run_txn(int'($urandom_range(0, 2)), 2, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/matrix_result_drain.md
# matrix_result_drain

Output-side companion to the 3x3 systolic multiplier array. On a `start` pulse it clears the array accumulators, waits a fixed settle window while the input feeder skews operands through the array, then snapshots all nine 8-bit PE results. It streams them row-major (C00..C22) over a valid/ready port and pulses `done` after the last beat is accepted. It sits between the PE array's `C` outputs and downstream consumers such as a bus writer or UART.

## Interface
- `SETTLE_CYCLES`, default 8: cycles from the `acc_clear` cycle to the snapshot edge, inclusive. Legal range is 1..15.
- `clk`  in  1  single clock; all logic is posedge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin one result cycle. Sampled only in IDLE; ignored otherwise.
- `c0`..`c8`  in  8 each  PE results, row-major (`c0`=C00, `c1`=C01, ..., `c8`=C22).
- `acc_clear`  out  1  one-cycle pulse that zeroes the PE accumulators.
- `out_data`  out  8  current result element.
- `out_index`  out  4  element index 0..8 of `out_data`.
- `out_valid`  out  1  `out_data`/`out_index` are valid.
- `out_ready`  in  1  consumer accepts the beat when `out_valid & out_ready`.
- `out_last`  out  1  high with `out_valid` when `out_index`==8.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States are IDLE, SETTLE, STREAM and DONE, held in a 2-bit encoding.
- IDLE: if `start`=1 at an edge, go to SETTLE and set `cnt`=0. `acc_clear`=1 during the first SETTLE cycle only.
- SETTLE: `cnt` increments each cycle. On the edge where `cnt`==SETTLE_CYCLES-1:
  - latch `c0`..`c8` into a 9x8 snapshot buffer;
  - set `idx`=0;
  - go to STREAM.
- STREAM: `out_valid`=1, `out_data`=buf[`idx`], `out_index`=`idx`.
  - On an accepted beat with `idx`<8: increment `idx`.
  - On an accepted beat with `idx`==8: go to DONE.
  - Without acceptance: hold all outputs stable (AXI-style; no retraction).
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is ignored during DONE.
- The snapshot buffer decouples the output stream from the array, so `c*` may change freely after the snapshot edge.
- Widths:
  - results are passed through unmodified, with no truncation or sign handling;
  - `cnt` is 4 bits;
  - `idx` is 4 bits and never exceeds 8.

## Timing
- Reset (`reset`=0 at an edge):
  - state goes to IDLE;
  - `cnt`, `idx`, `out_data`, `out_index` = 0;
  - `out_valid`, `out_last`, `acc_clear`, `busy`, `done` = 0.
  - The snapshot buffer is cleared to 0.
- Reset mid-SETTLE or mid-STREAM aborts immediately: no partial `done`, and the stream restarts only on a new `start`.
- Latency: `start` edge T → `acc_clear` during cycle T+1 → snapshot at edge T+SETTLE_CYCLES → first `out_valid` at cycle T+SETTLE_CYCLES+1.
- With `out_ready` tied high, the 9 beats occupy consecutive cycles, `done` follows in the next cycle, and `busy` drops one cycle after that.
- Minimum start-to-start spacing is SETTLE_CYCLES+11 cycles. `start` held high continuously restarts only from IDLE.
- `busy` is registered from state; `out_*` and `done` are registered outputs.

## Structure
- Shared package `matrix_pkg` holds:
  - `N_ELEM`=9, `DATA_W`=8, `IDX_W`=4;
  - the state enum `drain_state_t`;
  - default `SETTLE_CYCLES`, which is shared with the feeder so both agree on array latency.
- One natural sub-module, `result_snapshot_buf`: a 9x8 parallel-load register with read-mux by index. The FSM, counters and handshake stay in the top.

## Test plan
- **Basic stream.** Drive `c0..c8`=1..9, pulse `start`, `out_ready`=1.
  - `acc_clear` is high 1 cycle after `start`.
  - Beats are 1,2,...,9 with indices 0..8, starting at cycle SETTLE_CYCLES+1.
  - `out_last` is high only on value 9; `done` pulses once in the next cycle.
- **Snapshot isolation.** After the snapshot edge, change `c*` to 0xFF. The stream still emits 1..9.
- **Backpressure.** Toggle `out_ready` 1,0,0,1,... During stalls, `out_data`/`out_index` hold stable with `out_valid`=1. All 9 beats arrive exactly once, in order.
- **Start while busy.** Pulse `start` during SETTLE, during STREAM and during the DONE cycle.
  - No restart and no extra `acc_clear`.
  - Exactly one `done` per accepted `start`.
- **Reset mid-stream.** Drive `reset`=0 after beat 4 is accepted.
  - The next cycle shows IDLE, with `out_valid`, `busy` and `done` = 0.
  - A fresh `start` yields a full 9-beat stream of the current `c*`.
- **Parameter sweep.** Run with SETTLE_CYCLES=1 and 15, and with back-to-back `start` immediately after `busy` falls.
  - The first beat appears at exactly T+SETTLE_CYCLES+1.
  - The second run is correct.
